// File: rtl/ssd_scan_pager.sv
// ssd_scan_pager
// ----------------------------------------------------------------------------
// Multiplexed seven-segment debug display driver. Shows a DATA_W-bit value as
// hex across DIGITS digits. A value wider than the display is split into
// PAGES = DATA_W/(4*DIGITS) pages, and a debounced push-button steps through
// them.
//
// Ports:
//   clk      in   board clock, all state on the rising edge
//   rst      in   synchronous, active-high reset
//   data_in  in   [DATA_W-1:0] value to display, sampled once per full scan
//   page_btn in   raw asynchronous push-button (high = pressed), bouncing
//   C        out  [6:0] segments, active-low, C[0]=a .. C[6]=g, registered
//   AN       out  [DIGITS-1:0] digit enables, active-low one-hot, AN[0] is the
//                 rightmost digit, registered
//   page     out  [2:0] current page index, registered
//
// Optional build macro:
//   SSD_LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                              non-zero nibble of the current page are blanked
//                              (digit 0 is never blanked).
// ----------------------------------------------------------------------------
module ssd_scan_pager #(
  parameter int DIGITS       = 4,
  parameter int DATA_W       = 32,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              page_btn,
  output logic [6:0]        C,
  output logic [DIGITS-1:0] AN,
  output logic [2:0]        page
);

  localparam int PAGES = DATA_W / (4 * DIGITS);
  localparam int NIBS  = DATA_W / 4;
  localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int NW    = (NIBS > 1) ? $clog2(NIBS) : 1;

  // Active-low hex glyphs, bit 0 = segment a.
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan state
  logic [RW-1:0]     refresh_cnt_q, refresh_cnt_d;
  logic [DW-1:0]     digit_idx_q, digit_idx_d;
  logic [DATA_W-1:0] snapshot_q, snapshot_d;

  // Debounce state
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [CW-1:0]     deb_cnt_q, deb_cnt_d;
  logic              stable_q, stable_d;
  logic              stable_prev_q, stable_prev_d;

  // Output state
  logic [2:0]        page_q, page_d;
  logic [6:0]        c_q, c_d;
  logic [DIGITS-1:0] an_q, an_d;

  // First cycle of each full scan: the snapshot loads and the digit being
  // driven this cycle is taken straight from data_in, so the whole scan
  // shows one consistent value.
  logic              load;
  logic [DATA_W-1:0] src;
  logic [3:0]        src_nib [NIBS];
  logic [NW-1:0]     nib_idx;
  logic              blank;

  assign load = (refresh_cnt_q == '0) && (digit_idx_q == '0);
  assign src  = load ? data_in : snapshot_q;

  for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib
    assign src_nib[gi] = src[4*gi +: 4];
  end

  assign nib_idx = NW'(int'(page_q) * DIGITS + int'(digit_idx_q));

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // Blank when every nibble of this page from the current digit upward is
  // zero; digit 0 always shows its glyph.
  always_comb begin
    blank = (digit_idx_q != '0);
    for (int d = 0; d < DIGITS; d++) begin
      if ((d >= int'(digit_idx_q)) &&
          (src_nib[NW'(int'(page_q) * DIGITS + d)] != 4'h0)) begin
        blank = 1'b0;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    digit_idx_d   = digit_idx_q;
    snapshot_d    = snapshot_q;
    sync1_d       = page_btn;
    sync2_d       = sync1_q;
    deb_cnt_d     = deb_cnt_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    page_d        = page_q;

    // Refresh divider and digit scan
    if (refresh_cnt_q == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      digit_idx_d   = (digit_idx_q == DW'(DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + 1'b1;
    end

    if (load) begin
      snapshot_d = data_in;
    end

    // Debounce: count while the synchronised level disagrees with the
    // accepted level; any agreement restarts the count.
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        stable_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_d = '0;
    end

    // One page step per accepted press (rising edge of the stable level)
    if ((PAGES > 1) && stable_q && !stable_prev_q) begin
      page_d = (page_q == 3'(PAGES - 1)) ? 3'd0 : page_q + 3'd1;
    end

    an_d = ~(DIGITS'(1) << digit_idx_q);
    c_d  = blank ? 7'h7F : hex7seg(src_nib[nib_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      snapshot_q    <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      deb_cnt_q     <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      page_q        <= 3'd0;
      c_q           <= 7'h7F;
      an_q          <= '1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      snapshot_q    <= snapshot_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_cnt_q     <= deb_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      page_q        <= page_d;
      c_q           <= c_d;
      an_q          <= an_d;
    end
  end

  assign C    = c_q;
  assign AN   = an_q;
  assign page = page_q;

endmodule

// File: tb/tb_ssd_scan_pager.sv
// Self-checking bench for ssd_scan_pager with DIGITS=4, DATA_W=32,
// REFRESH_DIV=4, DEBOUNCE_CYC=8. Expected display values are pushed to a
// scoreboard queue as each cycle's stimulus is applied and popped after the
// clock edge that should produce them.
module tb_ssd_scan_pager;
  localparam int DIGITS       = 4;
  localparam int DATA_W       = 32;
  localparam int REFRESH_DIV  = 4;
  localparam int DEBOUNCE_CYC = 8;
  localparam int SCAN         = REFRESH_DIV * DIGITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              page_btn = 1'b0;
  logic [6:0]        C;
  logic [DIGITS-1:0] AN;
  logic [2:0]        page;

  always #5 clk = ~clk;

  ssd_scan_pager #(
    .DIGITS(DIGITS), .DATA_W(DATA_W),
    .REFRESH_DIV(REFRESH_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .page_btn(page_btn),
    .C(C), .AN(AN), .page(page)
  );

  typedef struct {
    logic [6:0]        c;
    logic [DIGITS-1:0] an;
    bit                chk;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  int          k      = 0;       // cycles since reset release
  logic [31:0] snap_m = '0;
  int          page_m = 0;
  bit          chk_disp = 1'b1;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] model_seg(logic [31:0] v, int pg, int dig);
    int base;
    bit blank;
    base  = pg * DIGITS;
    blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (dig != 0) begin
      blank = 1'b1;
      for (int d = dig; d < DIGITS; d++)
        if (v[4*(base+d) +: 4] != 4'h0) blank = 1'b0;
    end
`endif
    return blank ? 7'h7F : glyph[v[4*(base+dig) +: 4]];
  endfunction

  // Push the expectation for this cycle's inputs, then advance one edge.
  task automatic step();
    exp_t e;
    int   dig;
    if (rst) begin
      k = 0; snap_m = '0; page_m = 0;
      e.c = 7'h7F; e.an = '1;
    end else begin
      dig = (k / REFRESH_DIV) % DIGITS;
      if ((k % SCAN) == 0) snap_m = data_in;
      e.c  = model_seg(snap_m, page_m, dig);
      e.an = ~(DIGITS'(1) << dig);
      k++;
    end
    e.chk = chk_disp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an || page !== 3'd0)
        $display("FAIL reset_hold C=%h AN=%h page=%0d want C=%h AN=%h page=0", C, AN, page, e.c, e.an);
      else passed++;
    end
    rst = 1'b0;
    total++;
    if (C !== 7'h7F || AN !== 4'hF)
      $display("FAIL reset_first C=%h AN=%h want C=7f AN=f", C, AN);
    else passed++;
    data_in = 32'h0000_0000;
    for (int i = 0; i < 2 * SCAN; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL scan_seq cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
  endtask

  task automatic test_hex();
    exp_t e;
    data_in = 32'h89AB_CDEF;
    for (int i = 0; i < 2 * SCAN; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL hex_page0 cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
  endtask

  task automatic test_snapshot();
    exp_t e;
    data_in = 32'h0000_1234;
    for (int i = 0; i < SCAN + 6; i++) begin
      if (i >= 6 && (k % SCAN) == 6) data_in = 32'h0000_5678;
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL snapshot cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
    for (int i = 0; i < 2 * SCAN; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL snapshot_next cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    data_in = 32'h0000_ABCD;
    repeat (7) begin step(); void'(sb.pop_front()); end
    rst = 1'b1;
    step(); e = sb.pop_front();
    total++;
    if (C !== 7'h7F || AN !== 4'hF || page !== 3'd0)
      $display("FAIL reset_mid C=%h AN=%h page=%0d want C=7f AN=f page=0", C, AN, page);
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < SCAN + 4; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL after_reset_mid cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
  endtask

  task automatic test_debounce();
    logic [2:0] prev;
    int         changes;
    chk_disp = 1'b0;
    for (int g = 0; g < 3; g++) begin
      page_btn = 1'b1;
      for (int i = 0; i < 15; i++) begin
        if (i == 5) page_btn = 1'b0;
        step(); void'(sb.pop_front());
        total++;
        if (page !== 3'd0) $display("FAIL glitch g=%0d cyc=%0d page=%0d want 0", g, i, page);
        else passed++;
      end
    end
    page_btn = 1'b1;
    prev = page;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      step(); void'(sb.pop_front());
      if (page !== prev) changes++;
      prev = page;
      if (i < DEBOUNCE_CYC) begin
        total++;
        if (page !== 3'd0) $display("FAIL press_early cyc=%0d page=%0d want 0", i, page);
        else passed++;
      end
    end
    total++;
    if (page !== 3'd1) $display("FAIL press_page page=%0d want 1", page);
    else passed++;
    total++;
    if (changes != 1) $display("FAIL press_steps changes=%0d want 1", changes);
    else passed++;
    page_btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(); void'(sb.pop_front());
      total++;
      if (page !== 3'd1) $display("FAIL release cyc=%0d page=%0d want 1", i, page);
      else passed++;
    end
    page_m = 1;
    chk_disp = 1'b1;
  endtask

  task automatic test_page1();
    exp_t e;
    data_in = 32'h89AB_CDEF;
    for (int i = 0; i < 2 * SCAN; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL page1 cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    chk_disp = 1'b0;
    page_btn = 1'b1;
    repeat (20) begin step(); void'(sb.pop_front()); end
    page_btn = 1'b0;
    repeat (20) begin step(); void'(sb.pop_front()); end
    total++;
    if (page !== 3'd0) $display("FAIL wrap page=%0d want 0", page);
    else passed++;
    page_m = 0;
    chk_disp = 1'b1;
    for (int i = 0; i < SCAN; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL wrap_disp cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
  endtask

`ifdef SSD_LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    exp_t e;
    data_in = 32'h0000_0050;
    for (int i = 0; i < 2 * SCAN; i++) begin
      if (i == SCAN) data_in = 32'h0000_0000;
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL blank cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
    for (int i = 0; i < SCAN; i++) begin
      step(); e = sb.pop_front();
      total++;
      if (C !== e.c || AN !== e.an)
        $display("FAIL blank_zero cyc=%0d C=%h AN=%h want C=%h AN=%h", i, C, AN, e.c, e.an);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hex();
    test_snapshot();
    test_reset_mid();
    test_debounce();
    test_page1();
    test_wrap();
`ifdef SSD_LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
